// File: rtl/mem_wb_stage_pkg.sv
// Shared types and widths for the MEM/WB pipeline slice: datapath widths,
// memory-handshake FSM states and the packed pipeline-register layouts.
package mem_wb_stage_pkg;

   localparam int RISC_V_DATA_WIDTH           = 32;
   localparam int REGISTER_FILE_ADDRESS_WIDTH = 5;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic                                   valid;
      logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] rd;
      logic                                   reg_w;
      logic                                   mem_r;
      logic                                   mem_w;
      logic                                   mem_to_reg;
      logic [RISC_V_DATA_WIDTH-1:0]           alu;
      logic [RISC_V_DATA_WIDTH-1:0]           store_data;
   } exmem_reg_t;

   typedef struct packed {
      logic                                   valid;
      logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] rd;
      logic                                   reg_w;
      logic [RISC_V_DATA_WIDTH-1:0]           data;
   } memwb_reg_t;

endpackage

// File: rtl/mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers with a stalling data-memory handshake,
// forwarding taps, register-file write port and a saturating stall counter.
module mem_wb_stage #(
   parameter int RISC_V_DATA_WIDTH           = mem_wb_stage_pkg::RISC_V_DATA_WIDTH,
   parameter int REGISTER_FILE_ADDRESS_WIDTH = mem_wb_stage_pkg::REGISTER_FILE_ADDRESS_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   ex_valid,
   input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ex_rd,
   input  logic                                   ex_ctrl_reg_w,
   input  logic                                   ex_ctrl_mem_r,
   input  logic                                   ex_ctrl_mem_w,
   input  logic                                   ex_ctrl_mem_to_reg,
   input  logic [RISC_V_DATA_WIDTH-1:0]           ex_ALU_data_out,
   input  logic [RISC_V_DATA_WIDTH-1:0]           ex_store_data,
   output logic                                   stall,
   output logic                                   mem_req,
   output logic                                   mem_we,
   output logic [RISC_V_DATA_WIDTH-1:0]           mem_addr,
   output logic [RISC_V_DATA_WIDTH-1:0]           mem_wdata,
   input  logic                                   mem_ack,
   input  logic [RISC_V_DATA_WIDTH-1:0]           mem_rdata,
   output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] exmem_rd,
   output logic                                   exmem_ctrl_reg_w,
   output logic [RISC_V_DATA_WIDTH-1:0]           exmem_ALU_data_out,
   output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] memwb_rd,
   output logic                                   memwb_ctrl_reg_w,
   output logic [RISC_V_DATA_WIDTH-1:0]           memwb_mux_read_data,
   output logic                                   rf_we,
   output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] rf_waddr,
   output logic [RISC_V_DATA_WIDTH-1:0]           rf_wdata,
   output logic [15:0]                            stall_cycles
);

   import mem_wb_stage_pkg::*;

   mem_state_e  r_state;
   mem_state_e  w_state_next;
   exmem_reg_t  r_exmem;
   memwb_reg_t  r_memwb;
   logic [15:0] r_stall_cycles;
   logic        w_mem_req;
   logic        w_mem_ack;
   logic        w_stall;

   // An ack with no request outstanding is meaningless and is dropped here.
   assign w_mem_req = r_exmem.valid & (r_exmem.mem_r | r_exmem.mem_w);
   assign w_mem_ack = w_mem_req & mem_ack;
   assign w_stall   = w_mem_req & ~mem_ack;

   // NOTE: always_comb assigns every output a default first so no path leaves
   // a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:     if (w_mem_req && !w_mem_ack) w_state_next = ST_WAIT_MEM;
         ST_WAIT_MEM: if (w_mem_ack)               w_state_next = ST_IDLE;
         default:                                  w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exmem <= '0;
      end else if (!w_stall) begin
         if (ex_valid) begin
            r_exmem <= '{valid:      1'b1,
                         rd:         ex_rd,
                         reg_w:      ex_ctrl_reg_w,
                         mem_r:      ex_ctrl_mem_r,
                         mem_w:      ex_ctrl_mem_w,
                         mem_to_reg: ex_ctrl_mem_to_reg,
                         alu:        ex_ALU_data_out,
                         store_data: ex_store_data};
         end else begin
            r_exmem <= '0;
         end
      end
   end

   // A stalled edge pushes a bubble so the held instruction writes back once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_memwb <= '0;
      end else if (w_stall) begin
         r_memwb <= '0;
      end else begin
         r_memwb <= '{valid: r_exmem.valid,
                      rd:    r_exmem.rd,
                      reg_w: r_exmem.reg_w,
                      data:  r_exmem.mem_to_reg ? mem_rdata : r_exmem.alu};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    r_stall_cycles <= '0;
      else if (w_stall && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
   end

   assign stall               = w_stall;
   assign mem_req             = w_mem_req;
   assign mem_we              = r_exmem.mem_w;
   assign mem_addr            = r_exmem.alu;
   assign mem_wdata           = r_exmem.store_data;
   assign exmem_rd            = r_exmem.rd;
   assign exmem_ctrl_reg_w    = r_exmem.valid & r_exmem.reg_w;
   assign exmem_ALU_data_out  = r_exmem.alu;
   assign memwb_rd            = r_memwb.rd;
   assign memwb_ctrl_reg_w    = r_memwb.valid & r_memwb.reg_w;
   assign memwb_mux_read_data = r_memwb.data;
   assign rf_we               = memwb_ctrl_reg_w & (r_memwb.rd != '0);
   assign rf_waddr            = r_memwb.rd;
   assign rf_wdata            = r_memwb.data;
   assign stall_cycles        = r_stall_cycles;

   // WAIT_MEM is only reachable with a request held stable until its ack.
   a_wait_has_req: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == ST_WAIT_MEM) |-> w_mem_req);
   a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      w_stall |=> (w_mem_req && $stable(mem_we) && $stable(mem_addr) && $stable(mem_wdata)));

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, reset and
// saturation sequences, then random traffic against a stage-level model.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   localparam int DW = RISC_V_DATA_WIDTH;
   localparam int AW = REGISTER_FILE_ADDRESS_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ex_valid, ex_ctrl_reg_w, ex_ctrl_mem_r, ex_ctrl_mem_w, ex_ctrl_mem_to_reg;
   logic [AW-1:0] ex_rd;
   logic [DW-1:0] ex_ALU_data_out, ex_store_data;
   logic          stall, mem_req, mem_we, mem_ack;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [AW-1:0] exmem_rd, memwb_rd, rf_waddr;
   logic          exmem_ctrl_reg_w, memwb_ctrl_reg_w, rf_we;
   logic [DW-1:0] exmem_ALU_data_out, memwb_mux_read_data, rf_wdata;
   logic [15:0]   stall_cycles;

   mem_wb_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_ctrl_reg_w(ex_ctrl_reg_w), .ex_ctrl_mem_r(ex_ctrl_mem_r),
      .ex_ctrl_mem_w(ex_ctrl_mem_w), .ex_ctrl_mem_to_reg(ex_ctrl_mem_to_reg),
      .ex_ALU_data_out(ex_ALU_data_out), .ex_store_data(ex_store_data),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .exmem_rd(exmem_rd), .exmem_ctrl_reg_w(exmem_ctrl_reg_w),
      .exmem_ALU_data_out(exmem_ALU_data_out),
      .memwb_rd(memwb_rd), .memwb_ctrl_reg_w(memwb_ctrl_reg_w),
      .memwb_mux_read_data(memwb_mux_read_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v; int rd; bit reg_w; bit mem_r; bit mem_w; bit m2r;
      int unsigned alu; int unsigned sd;
   } instr_t;

   typedef struct {
      instr_t ex; bit ack; int unsigned rdata;
   } stim_t;

   typedef struct {
      bit v; int rd; bit reg_w; int unsigned data;
   } wb_t;

   typedef struct {
      bit stall; bit req; bit we; int unsigned addr; int unsigned wdata;
      bit exw; bit wbw; bit rfwe; int waddr; int unsigned rfdata; int sc;
   } exp_t;

   typedef struct { stim_t s; exp_t e; } row_t;

   int total = 0;
   int bad   = 0;

   // Reference model: the instruction sitting in each stage plus a stall tally.
   instr_t m_ex;
   wb_t    m_wb;
   int     m_stalls;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t mk(bit v, int rd, bit rw, bit mr, bit mw, bit m2r,
                                int unsigned alu, int unsigned sd, bit ack, int unsigned rdata);
      stim_t s;
      s.ex = '{v:v, rd:rd, reg_w:rw, mem_r:mr, mem_w:mw, m2r:m2r, alu:alu, sd:sd};
      s.ack = ack;
      s.rdata = rdata;
      return s;
   endfunction

   function automatic exp_t ex(bit st, bit rq, bit we, int unsigned ad, int unsigned wd,
                               bit exw, bit wbw, bit rfwe, int wa, int unsigned rfd, int sc);
      exp_t e;
      e = '{stall:st, req:rq, we:we, addr:ad, wdata:wd, exw:exw, wbw:wbw,
            rfwe:rfwe, waddr:wa, rfdata:rfd, sc:sc};
      return e;
   endfunction

   task automatic model_reset();
      m_ex = '{default:0};
      m_wb = '{default:0};
      m_stalls = 0;
   endtask

   task automatic drive(input stim_t s);
      int rd_v;
      rd_v               = s.ex.rd;
      ex_valid           = s.ex.v;
      ex_rd              = rd_v[AW-1:0];
      ex_ctrl_reg_w      = s.ex.reg_w;
      ex_ctrl_mem_r      = s.ex.mem_r;
      ex_ctrl_mem_w      = s.ex.mem_w;
      ex_ctrl_mem_to_reg = s.ex.m2r;
      ex_ALU_data_out    = s.ex.alu;
      ex_store_data      = s.ex.sd;
      mem_ack            = s.ack;
      mem_rdata          = s.rdata;
   endtask

   // Drive at the falling edge, then compare against the model mid-cycle.
   task automatic apply(input stim_t s, input bit do_check);
      bit req, stl, wbw;
      @(negedge clk);
      drive(s);
      #2;
      if (do_check) begin
         req = m_ex.v && (m_ex.mem_r || m_ex.mem_w);
         stl = req && !s.ack;
         wbw = m_wb.v && m_wb.reg_w;
         check("stall", stall, stl);
         check("mem_req", mem_req, req);
         check("mem_we", mem_we, m_ex.v && m_ex.mem_w);
         if (req) begin
            check("mem_addr", mem_addr, m_ex.alu);
            check("mem_wdata", mem_wdata, m_ex.sd);
         end
         check("exmem_reg_w", exmem_ctrl_reg_w, m_ex.v && m_ex.reg_w);
         if (m_ex.v && m_ex.reg_w) begin
            check("exmem_rd", exmem_rd, m_ex.rd);
            check("exmem_alu", exmem_ALU_data_out, m_ex.alu);
         end
         check("memwb_reg_w", memwb_ctrl_reg_w, wbw);
         check("rf_we", rf_we, wbw && (m_wb.rd != 0));
         if (wbw) begin
            check("memwb_rd", memwb_rd, m_wb.rd);
            check("memwb_data", memwb_mux_read_data, m_wb.data);
            check("rf_waddr", rf_waddr, m_wb.rd);
            check("rf_wdata", rf_wdata, m_wb.data);
         end
         check("stall_cycles", stall_cycles, m_stalls);
      end
   endtask

   // Advance the model across the rising edge that closes the current cycle.
   task automatic finish_cycle(input stim_t s);
      bit stl;
      @(posedge clk);
      stl = m_ex.v && (m_ex.mem_r || m_ex.mem_w) && !s.ack;
      if (stl) begin
         m_wb = '{default:0};
         if (m_stalls < 65535) m_stalls++;
      end else begin
         m_wb = '{v:m_ex.v, rd:m_ex.rd, reg_w:m_ex.reg_w,
                  data: m_ex.m2r ? s.rdata : m_ex.alu};
         m_ex = s.ex.v ? s.ex : '{default:0};
      end
   endtask

   task automatic step(input stim_t s);
      apply(s, 1'b1);
      finish_cycle(s);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_stall", stall, 0);
      check("rst_rf_we", rf_we, 0);
      check("rst_stall_cycles", stall_cycles, 0);
      check("rst_exmem_reg_w", exmem_ctrl_reg_w, 0);
      check("rst_memwb_reg_w", memwb_ctrl_reg_w, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   row_t tbl[14];

   initial begin
      stim_t s;
      // Hand-derived cycle-by-cycle vectors; row i's inputs and expectations
      // share one cycle (EX/MEM holds row i-1, MEM/WB holds row i-2).
      tbl[0]  = '{mk(1,5,1,0,0,0,'h1234,0,0,0),            ex(0,0,0,0,0, 0,0,0,0,0,0)};
      tbl[1]  = '{mk(0,0,0,0,0,0,0,0,0,0),                 ex(0,0,0,0,0, 1,0,0,0,0,0)};
      tbl[2]  = '{mk(1,7,1,1,0,1,'h100,0,0,0),             ex(0,0,0,0,0, 0,1,1,5,'h1234,0)};
      tbl[3]  = '{mk(0,0,0,0,0,0,0,0,1,'hDEADBEEF),        ex(0,1,0,'h100,0, 1,0,0,0,0,0)};
      tbl[4]  = '{mk(0,0,0,0,0,0,0,0,0,0),                 ex(0,0,0,0,0, 0,1,1,7,'hDEADBEEF,0)};
      tbl[5]  = '{mk(1,9,1,1,0,1,'h200,0,0,0),             ex(0,0,0,0,0, 0,0,0,0,0,0)};
      tbl[6]  = '{mk(0,0,0,0,0,0,0,0,0,0),                 ex(1,1,0,'h200,0, 1,0,0,0,0,0)};
      tbl[7]  = '{mk(1,3,1,0,0,0,'h55,0,0,0),              ex(1,1,0,'h200,0, 1,0,0,0,0,1)};
      tbl[8]  = '{mk(1,3,1,0,0,0,'h55,0,1,'hCAFEF00D),     ex(0,1,0,'h200,0, 1,0,0,0,0,2)};
      tbl[9]  = '{mk(1,0,0,0,1,0,'h300,'hA5A55A5A,0,0),    ex(0,0,0,0,0, 1,1,1,9,'hCAFEF00D,2)};
      tbl[10] = '{mk(1,0,1,0,0,0,'h77,0,1,0),              ex(0,1,1,'h300,'hA5A55A5A, 0,1,1,3,'h55,2)};
      tbl[11] = '{mk(0,0,0,0,0,0,0,0,0,0),                 ex(0,0,0,0,0, 1,0,0,0,0,2)};
      tbl[12] = '{mk(0,0,0,0,0,0,0,0,0,0),                 ex(0,0,0,0,0, 0,1,0,0,0,2)};
      tbl[13] = '{mk(0,0,0,0,0,0,0,0,0,0),                 ex(0,0,0,0,0, 0,0,0,0,0,2)};

      model_reset();
      do_reset();

      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].s, 1'b1);
         check($sformatf("t%0d_stall", i), stall, tbl[i].e.stall);
         check($sformatf("t%0d_req", i), mem_req, tbl[i].e.req);
         check($sformatf("t%0d_we", i), mem_we, tbl[i].e.we);
         if (tbl[i].e.req) begin
            check($sformatf("t%0d_addr", i), mem_addr, tbl[i].e.addr);
            check($sformatf("t%0d_wdata", i), mem_wdata, tbl[i].e.wdata);
         end
         check($sformatf("t%0d_exmem_w", i), exmem_ctrl_reg_w, tbl[i].e.exw);
         check($sformatf("t%0d_memwb_w", i), memwb_ctrl_reg_w, tbl[i].e.wbw);
         check($sformatf("t%0d_rf_we", i), rf_we, tbl[i].e.rfwe);
         if (tbl[i].e.rfwe) begin
            check($sformatf("t%0d_waddr", i), rf_waddr, tbl[i].e.waddr);
            check($sformatf("t%0d_rfdata", i), rf_wdata, tbl[i].e.rfdata);
         end
         check($sformatf("t%0d_sc", i), stall_cycles, tbl[i].e.sc);
         finish_cycle(tbl[i].s);
      end

      // Reset asserted while a load waits for its ack; a late ack must not write back.
      step(mk(1,12,1,1,0,1,'h400,0,0,0));
      step(mk(0,0,0,0,0,0,0,0,0,0));
      step(mk(0,0,0,0,0,0,0,0,0,0));
      apply(mk(0,0,0,0,0,0,0,0,0,0), 1'b1);
      check("mid_wait_stall", stall, 1);
      #1 rst_n = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 'h1111;
      #1;
      check("mid_rst_mem_req", mem_req, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_rf_we", rf_we, 0);
      check("mid_rst_sc", stall_cycles, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_exmem_w", exmem_ctrl_reg_w, 0);
      check("mid_rst_memwb_w", memwb_ctrl_reg_w, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         step(mk(0,0,0,0,0,0,0,0,1,'h1111));
         check("late_ack_rf_we", rf_we, 0);
      end

      // Long stall: counter must saturate, then a single write-back follows.
      do_reset();
      step(mk(1,20,1,1,0,1,'h500,0,0,0));
      for (int i = 0; i < 70000; i++) begin
         s = mk(0,0,0,0,0,0,0,0,0,0);
         apply(s, 1'b0);
         finish_cycle(s);
      end
      apply(mk(0,0,0,0,0,0,0,0,0,0), 1'b1);
      check("sat_value", stall_cycles, 'hFFFF);
      check("sat_stall", stall, 1);
      finish_cycle(mk(0,0,0,0,0,0,0,0,0,0));
      step(mk(0,0,0,0,0,0,0,0,1,'hBEEF0001));
      check("sat_hold", stall_cycles, 'hFFFF);
      step(mk(0,0,0,0,0,0,0,0,0,0));
      check("sat_wb_rf_we", rf_we, 1);
      check("sat_wb_data", rf_wdata, 'hBEEF0001);
      step(mk(0,0,0,0,0,0,0,0,0,0));
      check("sat_single_wb", rf_we, 0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         s = mk($urandom_range(0,3) != 0, $urandom_range(0,31), $urandom_range(0,1),
                $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
                $urandom, $urandom, $urandom_range(0,2) == 0, $urandom);
         step(s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
